// File: rtl/deslocamento_pkg.sv
// Shared widths and opcode encoding for the 64-bit registered barrel shifter.
package deslocamento_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned NBITS = 6;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

endpackage

// File: rtl/deslocamento_stage.sv
// One level of the logarithmic shifter: moves data by DIST when en is set,
// with the fill chosen by the opcode (zeros, sign copies or wrapped bits).
module deslocamento_stage
    import deslocamento_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = din;
        case (op)
            SHIFT_SLL: shifted = {din[WIDTH-1-DIST:0], {DIST{1'b0}}};
            SHIFT_SRL: shifted = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
            SHIFT_SRA: shifted = {{DIST{din[WIDTH-1]}}, din[WIDTH-1:DIST]};
            SHIFT_ROR: shifted = {din[DIST-1:0], din[WIDTH-1:DIST]};
            default:   shifted = din;
        endcase
    end

    assign dout = en ? shifted : din;

endmodule

// File: rtl/deslocamento.sv
// Registered 64-bit barrel shifter (SLL/SRL/SRA/ROR): six cascaded stages of
// distance 1..32 selected by N, result registered with one cycle of latency.
module deslocamento
    import deslocamento_pkg::*;
#(
    parameter int unsigned WIDTH = deslocamento_pkg::WIDTH,
    parameter int unsigned NBITS = deslocamento_pkg::NBITS
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [1:0]       Shift,
    input  logic [WIDTH-1:0] Entrada,
    input  logic [NBITS-1:0] N,
    output logic [WIDTH-1:0] Saida
);

    shift_op_t        op;
    logic [WIDTH-1:0] stg [0:NBITS];

    assign op     = shift_op_t'(Shift);
    assign stg[0] = Entrada;

    // Stage k owns bit k of N, so distances compose to any amount 0..WIDTH-1.
    for (genvar k = 0; k < NBITS; k++) begin : g_stage
        deslocamento_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .din  (stg[k]),
            .en   (N[k]),
            .op   (op),
            .dout (stg[k+1])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Saida <= '0;
        end else begin
            Saida <= stg[NBITS];
        end
    end

endmodule

// File: tb/tb_deslocamento.sv
// Directed vector bench for the registered barrel shifter, plus reset and
// timing sequences.
module tb_deslocamento;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  Shift;
    logic [63:0] Entrada;
    logic [5:0]  N;
    logic [63:0] Saida;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  sh;
        logic [63:0] e;
        logic [5:0]  n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [0:20];

    deslocamento #(
        .WIDTH (64),
        .NBITS (6)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Shift   (Shift),
        .Entrada (Entrada),
        .N       (N),
        .Saida   (Saida)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"sll_4_by_2",      2'b00, 64'h4,                  6'd2,  64'h10};
        vecs[1]  = '{"srl_by_1",        2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 6'd1,  64'h7FFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{"sra_neg_by_8",    2'b10, 64'hFFFF_FFFF_FFFF_FF00, 6'd8,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{"sra_pos_by_4",    2'b10, 64'h7000_0000_0000_0000, 6'd4,  64'h0700_0000_0000_0000};
        vecs[4]  = '{"ror_1_by_1",      2'b11, 64'h1,                  6'd1,  64'h8000_0000_0000_0000};
        vecs[5]  = '{"sra_msb_by_63",   2'b10, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6]  = '{"sll_1_by_63",     2'b00, 64'h1,                  6'd63, 64'h8000_0000_0000_0000};
        vecs[7]  = '{"sll_n0",          2'b00, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567};
        vecs[8]  = '{"srl_n0",          2'b01, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567};
        vecs[9]  = '{"sra_n0",          2'b10, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567};
        vecs[10] = '{"ror_n0",          2'b11, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567};
        vecs[11] = '{"srl_msb_by_63",   2'b01, 64'h8000_0000_0000_0000, 6'd63, 64'h1};
        vecs[12] = '{"ror_by_32",       2'b11, 64'hDEAD_BEEF_0123_4567, 6'd32, 64'h0123_4567_DEAD_BEEF};
        vecs[13] = '{"ror_f0_by_8",     2'b11, 64'h0000_0000_0000_00F0, 6'd8,  64'hF000_0000_0000_0000};
        vecs[14] = '{"srl_by_4",        2'b01, 64'hDEAD_BEEF_0123_4567, 6'd4,  64'h0DEA_DBEE_F012_3456};
        vecs[15] = '{"sra_by_4",        2'b10, 64'hDEAD_BEEF_0123_4567, 6'd4,  64'hFDEA_DBEE_F012_3456};
        vecs[16] = '{"sll_by_16",       2'b00, 64'hDEAD_BEEF_0123_4567, 6'd16, 64'hBEEF_0123_4567_0000};
        vecs[17] = '{"ror_by_63",       2'b11, 64'hDEAD_BEEF_0123_4567, 6'd63, 64'hBD5B_7DDE_0246_8ACF};
        vecs[18] = '{"sra_msb_by_1",    2'b10, 64'h8000_0000_0000_0000, 6'd1,  64'hC000_0000_0000_0000};
        vecs[19] = '{"srl_ones_by_63",  2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h1};
        vecs[20] = '{"sll_by_21",       2'b00, 64'h0000_0000_0000_0005, 6'd21, 64'h0000_0000_00A0_0000};

        // Reset asserted between edges with arbitrary inputs.
        Reset_n = 1'b1;
        Shift   = 2'b11;
        Entrada = 64'hDEAD_BEEF_0123_4567;
        N       = 6'd5;
        #2 Reset_n = 1'b0;
        #1 check("reset_async", Saida, 64'h0);
        @(posedge Clk); #1;
        check("reset_held", Saida, 64'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Inputs change every cycle; each result appears after exactly one edge.
        for (int i = 0; i <= 20; i++) begin
            Shift   = vecs[i].sh;
            Entrada = vecs[i].e;
            N       = vecs[i].n;
            @(posedge Clk); #1;
            check(vecs[i].name, Saida, vecs[i].exp);
            @(negedge Clk);
        end

        // Mid-cycle input change must not reach Saida before the next edge.
        Shift   = 2'b00; Entrada = 64'h3; N = 6'd4;
        @(posedge Clk); #1;
        check("midcycle_base", Saida, 64'h30);
        Shift = 2'b01; Entrada = 64'hFFFF_0000_0000_0000; N = 6'd16;
        #2 check("midcycle_hold", Saida, 64'h30);
        @(posedge Clk); #1;
        check("midcycle_next", Saida, 64'h0000_FFFF_0000_0000);

        // Reset asserted mid-operation discards the pending result.
        @(negedge Clk);
        Shift = 2'b11; Entrada = 64'hDEAD_BEEF_0123_4567; N = 6'd32;
        @(posedge Clk); #1;
        check("pre_reset_result", Saida, 64'h0123_4567_DEAD_BEEF);
        #1 Reset_n = 1'b0;
        #1 check("midop_reset_async", Saida, 64'h0);
        @(posedge Clk); #1;
        check("midop_reset_held", Saida, 64'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Shift = 2'b00; Entrada = 64'h1; N = 6'd63;
        #1 check("no_stale_after_release", Saida, 64'h0);
        @(posedge Clk); #1;
        check("first_after_release", Saida, 64'h8000_0000_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
